// File: rtl/cs_tri_stack_pkg.sv
// cs_tri_stack_pkg: triangle types and stack defaults shared by the clip/scan stack
package cs_tri_stack_pkg;
  localparam int CS_STACK_DEPTH = 8;
  localparam int COORD_W = 16;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] z;
  } vertex_t;
  typedef struct packed {
    vertex_t p;
    vertex_t q;
    vertex_t r;
  } Triangle3D;
endpackage

// File: rtl/cs_stack_regfile.sv
// cs_stack_regfile: unreset triangle storage, one write port, one async read port
module cs_stack_regfile
  import cs_tri_stack_pkg::*;
#(
  parameter int DEPTH = CS_STACK_DEPTH,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  Triangle3D     wdata_i,
  input  logic [AW-1:0] raddr_i,
  output Triangle3D     rdata_o
);
  Triangle3D mem_q [DEPTH];
  // storage is deliberately left unreset; the count decides what is live
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/cs_tri_stack.sv
// cs_tri_stack: LIFO of triangles with peek, replace/bypass and sticky error flags
module cs_tri_stack
  import cs_tri_stack_pkg::*;
#(
  parameter int DEPTH = CS_STACK_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       err_clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  Triangle3D                  tri_i,
  output Triangle3D                  tri_o,
  output logic                       out_valid_o,
  output Triangle3D                  top_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       almost_full_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  logic [CW-1:0] count_q, count_d;
  Triangle3D     tri_q, tri_d, rd_data;
  logic          ov_q, ov_d, ovf_q, ovf_d, udf_q, udf_d, we;
  logic [AW-1:0] waddr, raddr;
  assign raddr         = AW'(count_q - 1'b1);
  assign empty_o       = count_q == '0;
  assign full_o        = count_q == CW'(DEPTH);
  assign almost_full_o = count_q >= CW'(AF_LEVEL);
  assign top_o         = empty_o ? '0 : rd_data;
  assign count_o       = count_q;
  assign tri_o         = tri_q;
  assign out_valid_o   = ov_q;
  assign overflow_o    = ovf_q;
  assign underflow_o   = udf_q;
  cs_stack_regfile #(.DEPTH(DEPTH), .AW(AW)) u_rf (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (tri_i),
    .raddr_i (raddr),
    .rdata_o (rd_data)
  );
  // clear beats push/pop; a fresh error beats err_clr; replace writes over the old top
  always_comb begin
    count_d = count_q;
    tri_d   = tri_q;
    ov_d    = 1'b0;
    we      = 1'b0;
    waddr   = AW'(count_q);
    ovf_d   = ovf_q & ~err_clr_i;
    udf_d   = udf_q & ~err_clr_i;
    if (clear_i) begin
      count_d = '0;
    end else if (push_i && pop_i) begin
      ov_d  = 1'b1;
      tri_d = empty_o ? tri_i : top_o;
      we    = ~empty_o;
      waddr = raddr;
    end else if (push_i) begin
      ovf_d   = ovf_q & ~err_clr_i | full_o;
      we      = ~full_o;
      count_d = full_o ? count_q : count_q + 1'b1;
    end else if (pop_i) begin
      udf_d   = udf_q & ~err_clr_i | empty_o;
      ov_d    = ~empty_o;
      tri_d   = empty_o ? tri_q : top_o;
      count_d = empty_o ? count_q : count_q - 1'b1;
    end
  end
  // pointer, output register and error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tri_q   <= '0;
      ov_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tri_q   <= tri_d;
      ov_q    <= ov_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end
endmodule
